// File: rtl/xlu_if.sv
// Bus between the E-stage and the multiply/divide unit: operation and operands in,
// issue/status and HI/LO read data out.
interface xlu_if;
  // xlu_op is presented every cycle. A start-type op is accepted (start=1) only in a
  // cycle where busy=0; while busy=1 every op is dropped without side effects.
  logic [3:0]  xlu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] xlu_out;

  modport master (output xlu_op, A, B, input start, busy, HI, LO, xlu_out);
  modport slave  (input xlu_op, A, B, output start, busy, HI, LO, xlu_out);
endinterface

// File: rtl/xlu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div/madd/msub
// and serves mthi/mtlo/mfhi/mflo.
module xlu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  xlu_if.slave       bus,
  output logic [1:0] dbg_state
);
  localparam logic [3:0] OP_MULT  = 4'b0000, OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010, OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MTHI  = 4'b0100, OP_MTLO  = 4'b0101;
  localparam logic [3:0] OP_MFHI  = 4'b0110, OP_MFLO  = 4'b0111;
  localparam logic [3:0] OP_MADD  = 4'b1001, OP_MADDU = 4'b1010;
  localparam logic [3:0] OP_MSUB  = 4'b1011, OP_MSUBU = 4'b1100;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, DIV_RUN = 2'd2} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic [31:0] hi_q, lo_q, temp_hi, temp_lo;
  logic        commit_ok;

  logic        is_mul_op, is_div_op, signed_mul, signed_div, busy_w, start_w;
  logic [63:0] a_ext, b_ext, prod, acc, mul_res, div_res;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    is_mul_op  = bus.xlu_op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    is_div_op  = bus.xlu_op inside {OP_DIV, OP_DIVU};
    signed_mul = bus.xlu_op inside {OP_MULT, OP_MADD, OP_MSUB};
    signed_div = (bus.xlu_op == OP_DIV);
    busy_w     = (state != IDLE);
    start_w    = (is_mul_op || is_div_op) && !busy_w;
  end

  // Multiply: the low 64 bits of the extended product are exact for both signednesses.
  always_comb begin
    a_ext = signed_mul ? {{32{bus.A[31]}}, bus.A} : {32'b0, bus.A};
    b_ext = signed_mul ? {{32{bus.B[31]}}, bus.B} : {32'b0, bus.B};
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
    if (bus.xlu_op inside {OP_MADD, OP_MADDU})      mul_res = acc + prod;
    else if (bus.xlu_op inside {OP_MSUB, OP_MSUBU}) mul_res = acc - prod;
    else                                            mul_res = prod;
  end

  // Divide on magnitudes so 0x80000000 / -1 needs no special case; divisor forced
  // non-zero because a zero-divisor result is never committed.
  always_comb begin
    a_neg   = signed_div && bus.A[31];
    b_neg   = signed_div && bus.B[31];
    a_mag   = a_neg ? -bus.A : bus.A;
    b_mag   = (bus.B == 32'd0) ? 32'd1 : (b_neg ? -bus.B : bus.B);
    q_mag   = a_mag / b_mag;
    r_mag   = a_mag % b_mag;
    quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
    div_res = {rem, quo};
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:             if (start_w) state_n = is_div_op ? DIV_RUN : MUL_RUN;
      MUL_RUN, DIV_RUN: if (cnt == 4'd1) state_n = IDLE;
      default:          state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      temp_hi   <= '0;
      temp_lo   <= '0;
      cnt       <= '0;
      commit_ok <= 1'b0;
    end else if (start_w) begin
      {temp_hi, temp_lo} <= is_div_op ? div_res : mul_res;
      commit_ok          <= !(is_div_op && bus.B == 32'd0);
      cnt                <= is_div_op ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (busy_w) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && commit_ok) begin
        hi_q <= temp_hi;
        lo_q <= temp_lo;
      end
    end else if (bus.xlu_op == OP_MTHI) begin
      hi_q <= bus.A;
    end else if (bus.xlu_op == OP_MTLO) begin
      lo_q <= bus.A;
    end
  end

  always_comb begin
    bus.start = start_w;
    bus.busy  = busy_w;
    bus.HI    = hi_q;
    bus.LO    = lo_q;
    dbg_state = state;
    if (bus.xlu_op == OP_MFHI)      bus.xlu_out = hi_q;
    else if (bus.xlu_op == OP_MFLO) bus.xlu_out = lo_q;
    else                            bus.xlu_out = 32'd0;
  end
endmodule

// File: tb/tb_xlu.sv
// Directed plus randomized bench for xlu against a cycle-counting HI/LO reference model.
module tb_xlu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  xlu_if      xif();

  xlu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .bus(xif.slave), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural HI/LO, remaining busy cycles, pending result.
  logic [31:0] m_hi, m_lo;
  int          m_left;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_start_op(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd10, 4'd11, 4'd12};
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_left = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod, acc;
    logic [31:0] q, r;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && exp_q.size() > 0) {m_hi, m_lo} = exp_q.pop_front();
    end else if (is_start_op(op)) begin
      acc = {m_hi, m_lo};
      if (op inside {4'd0, 4'd9, 4'd11}) prod = 64'(longint'(int'(a)) * longint'(int'(b)));
      else                               prod = {32'b0, a} * {32'b0, b};
      case (op)
        4'd0, 4'd1:   exp_q.push_back(prod);
        4'd9, 4'd10:  exp_q.push_back(acc + prod);
        4'd11, 4'd12: exp_q.push_back(acc - prod);
        4'd2: if (b != 0) begin
          if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = a; r = 0; end
          else begin q = 32'(int'(a) / int'(b)); r = 32'(int'(a) % int'(b)); end
          exp_q.push_back({r, q});
        end
        4'd3: if (b != 0) exp_q.push_back({a % b, a / b});
        default: ;
      endcase
      m_left = (op inside {4'd2, 4'd3}) ? DC : MC;
    end else if (op == 4'd4) m_hi = a;
    else if (op == 4'd5) m_lo = a;
  endtask

  // One clock of stimulus: drive at negedge, check combinational/registered outputs,
  // then advance the model across the rising edge.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_out;
    @(negedge clk);
    xif.xlu_op = op; xif.A = a; xif.B = b;
    #1;
    exp_out = (op == 4'd6) ? m_hi : (op == 4'd7) ? m_lo : 32'd0;
    chk("start", 32'(xif.start), 32'(is_start_op(op) && m_left == 0));
    chk("busy", 32'(xif.busy), 32'(m_left > 0));
    chk("hi", xif.HI, m_hi);
    chk("lo", xif.LO, m_lo);
    chk("xlu_out", xif.xlu_out, exp_out);
    model_edge(op, a, b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd8, 32'd0, 32'd0);
  endtask

  task automatic expect_hl(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    chk({tag, "_hi"}, xif.HI, hi);
    chk({tag, "_lo"}, xif.LO, lo);
    chk({tag, "_idle"}, 32'(xif.busy), 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b1;
    xif.xlu_op = 4'd8; xif.A = 0; xif.B = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_hi", xif.HI, 32'd0);
    chk("rst_lo", xif.LO, 32'd0);
    chk("rst_busy", 32'(xif.busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    step(4'd0, 32'hFFFFFFFD, 32'd5);
    idle(MC);
    expect_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFF1);

    step(4'd3, 32'd7, 32'd2);
    idle(DC);
    expect_hl("divu", 32'd1, 32'd3);
    step(4'd2, 32'hFFFFFFF9, 32'd2);
    idle(DC);
    expect_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    step(4'd2, 32'h80000000, 32'hFFFFFFFF);
    idle(DC);
    expect_hl("div_ovf", 32'd0, 32'h80000000);

    step(4'd4, 32'd1, 32'd0);
    step(4'd5, 32'hFFFFFFFF, 32'd0);
    step(4'd10, 32'd1, 32'd1);
    idle(MC);
    expect_hl("maddu", 32'd2, 32'd0);
    step(4'd11, 32'd1, 32'd1);
    idle(MC);
    expect_hl("msub", 32'd1, 32'hFFFFFFFF);

    step(4'd4, 32'h1234, 32'd0);
    step(4'd5, 32'h5678, 32'd0);
    step(4'd2, 32'd9, 32'd0);
    idle(DC);
    expect_hl("div0", 32'h1234, 32'h5678);

    step(4'd0, 32'd3, 32'd4);
    step(4'd5, 32'hDEAD, 32'd0);
    step(4'd1, 32'd7, 32'd7);
    idle(MC - 2);
    expect_hl("ignored", 32'd0, 32'd12);

    step(4'd2, 32'd100, 32'd7);
    idle(3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", 32'(xif.busy), 32'd0);
    chk("midrst_hi", xif.HI, 32'd0);
    chk("midrst_lo", xif.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(DC + 2);
    expect_hl("postrst", 32'd0, 32'd0);
    step(4'd7, 32'd0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      step(op, a, b);
    end
    idle(DC + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
